awmc_actuator_drive: RTL and testbench
======================================

AWMC_ACTUATOR_DRIVE -- requirements
Module: awmc_actuator_drive

Interface
REQ-001 The block SHALL have parameter AGITATE_CYC, default 8: motor-on cycles per agitation direction (legal range 1..255).
REQ-002 The block SHALL have parameter DEAD_CYC, default 2: motor-off cycles between any direction change or stop (legal range 1..255).
REQ-003 The block SHALL have parameter RAMP_CYC, default 4: cycles per spin speed step (legal range 1..255).
REQ-004 The block SHALL have parameter BUZZ_CYC, default 6: buzzer-on cycles per completion event (legal range 1..255).
REQ-005 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port stage  input  3  controller stage code: 000 FILL, 001 WASH, 010 DRAIN, 011 RINSE, 100 SPIN, 111 IDLE/PAUSED, 101/110 illegal.
REQ-008 The block SHALL have port done  input  1  controller cycle-complete level; it stays high until controller reset.
REQ-009 The block SHALL have port fill_valve  output  1  water inlet valve open.
REQ-010 The block SHALL have port drain_valve  output  1  drain valve open.
REQ-011 The block SHALL have port motor_fwd  output  1  motor forward drive.
REQ-012 The block SHALL have port motor_rev  output  1  motor reverse drive.
REQ-013 The block SHALL have port motor_speed  output  2  00 off, 01 agitate/low, 10 mid, 11 full.
REQ-014 The block SHALL have port buzzer  output  1  completion buzzer.
REQ-015 The block SHALL have port fault  output  1  illegal stage code present.

Function
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the stage/done sample to the output.
REQ-017 fill_valve SHALL be 1 exactly when the sampled stage is FILL.
REQ-018 drain_valve SHALL be 1 exactly when the sampled stage is DRAIN or SPIN.
REQ-019 fault SHALL be 1 exactly when the sampled stage is 101 or 110; for an illegal stage, both valves SHALL be 0 and the motor FSM SHALL treat the stage as non-motor.
REQ-020 The motor FSM SHALL have states OFF, FWD, DEAD_F, REV, DEAD_R, SPIN, plus one 8-bit phase counter cleared on every state entry.
REQ-021 In OFF: stage WASH/RINSE SHALL cause a transition to FWD; stage SPIN SHALL cause a transition to SPIN; otherwise the FSM SHALL stay in OFF.
REQ-022 In FWD: motor_fwd=1, speed=01; after AGITATE_CYC cycles in FWD the FSM SHALL go to DEAD_F.
REQ-023 In REV: motor_rev=1, speed=01; after AGITATE_CYC cycles in REV the FSM SHALL go to DEAD_R.
REQ-024 In FWD/REV, if the stage leaves WASH/RINSE, the FSM SHALL go immediately to DEAD_F/DEAD_R respectively.
REQ-025 In DEAD_F/DEAD_R: motor_fwd=0, motor_rev=0, speed=00 for exactly DEAD_CYC cycles.
REQ-026 At the end of DEAD_F/DEAD_R: stage WASH/RINSE SHALL cause a transition to REV (from DEAD_F) or FWD (from DEAD_R); stage SPIN SHALL cause a transition to SPIN; otherwise the FSM SHALL go to OFF.
REQ-027 In SPIN: motor_fwd=1; speed SHALL start at 01, step to 10 after RAMP_CYC cycles, step to 11 after a further RAMP_CYC cycles, and hold at 11 with no wrap.
REQ-028 In SPIN, if the stage leaves SPIN, the FSM SHALL go to DEAD_F with speed=00.
REQ-029 motor_fwd and motor_rev SHALL never both be 1.
REQ-030 A change between motor_fwd=1 and motor_rev=1 SHALL always pass through at least DEAD_CYC all-off cycles.
REQ-031 Buzzer: a done rising edge, detected via a registered copy of done, SHALL load the buzz counter; buzzer=1 for BUZZ_CYC cycles, then 0.
REQ-032 A new done rising edge while the buzzer is active SHALL restart the full BUZZ_CYC count.
REQ-033 done held high SHALL NOT retrigger the buzzer.
REQ-034 Pause (stage→111) during WASH SHALL stop the motor through a dead band; on resume, agitation SHALL restart at FWD after the dead band completes.

Reset
REQ-035 While reset_n=0, all outputs SHALL be 0, the FSM SHALL be in OFF, all counters SHALL be 0, and the done register SHALL be 0.
REQ-036 Reset assertion SHALL take effect asynchronously, mid-operation included, de-energising all actuators immediately.
REQ-037 After reset_n rises, the first sampled done=1 SHALL count as a rising edge.

Verification
REQ-038 Scenario: defaults, stage=001 held 40 cycles → fwd 8 cycles, off 2, rev 8, off 2, repeating; fwd and rev never both high.
REQ-039 Scenario: stage=100 held 12 cycles → drain_valve=1, motor_fwd=1; speed 01 ×4, 10 ×4, then 11 held.
REQ-040 Scenario: stage=001 for 5 cycles, then 111 for 3, then 001 → motor off 2 cycles after the pause, idle, then fwd restarts at count 0 after the dead band.
REQ-041 Scenario: done 0→1 and held 20 cycles → buzzer=1 for exactly 6 cycles starting 1 cycle after the edge; no retrigger.
REQ-042 Scenario: stage=110 → fault=1 and all valves/motor 0 one cycle later; then stage=000 → fault=0, fill_valve=1.
REQ-043 Scenario: reset_n pulsed low mid-SPIN at speed 11 → all outputs 0 asynchronously; FSM back in OFF.

Source files
------------

// File: rtl/awmc_actuator_drive_if.sv
// Stage/done command inputs and actuator outputs of the washer drive block.
// The controller owns the master side; the drive block owns the slave side.
interface awmc_actuator_drive_if;
    logic [2:0] stage;
    logic       done;
    logic       fill_valve;
    logic       drain_valve;
    logic       motor_fwd;
    logic       motor_rev;
    logic [1:0] motor_speed;
    logic       buzzer;
    logic       fault;

    modport master (
        output stage, done,
        input  fill_valve, drain_valve, motor_fwd, motor_rev, motor_speed, buzzer, fault
    );

    modport slave (
        input  stage, done,
        output fill_valve, drain_valve, motor_fwd, motor_rev, motor_speed, buzzer, fault
    );
endinterface

// File: rtl/awmc_actuator_drive.sv
// Washer actuator drive: valves, dead-banded agitate/spin motor sequencing and
// completion buzzer. Every output is a register loaded from the sampled stage/done.
module awmc_actuator_drive #(
    parameter int unsigned AGITATE_CYC = 8,
    parameter int unsigned DEAD_CYC    = 2,
    parameter int unsigned RAMP_CYC    = 4,
    parameter int unsigned BUZZ_CYC    = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    awmc_actuator_drive_if.slave   bus
);

    localparam logic [7:0] AGITATE_LAST = 8'(AGITATE_CYC - 1);
    localparam logic [7:0] DEAD_LAST    = 8'(DEAD_CYC - 1);
    localparam logic [7:0] RAMP_LAST    = 8'(RAMP_CYC - 1);
    localparam logic [7:0] BUZZ_LOAD    = 8'(BUZZ_CYC);

    localparam logic [2:0] STAGE_FILL  = 3'b000;
    localparam logic [2:0] STAGE_WASH  = 3'b001;
    localparam logic [2:0] STAGE_DRAIN = 3'b010;
    localparam logic [2:0] STAGE_RINSE = 3'b011;
    localparam logic [2:0] STAGE_SPIN  = 3'b100;

    typedef enum logic [2:0] {
        ST_OFF, ST_FWD, ST_DEAD_F, ST_REV, ST_DEAD_R, ST_SPIN
    } motor_state_t;

    motor_state_t state, state_next;
    logic [7:0]   cnt, cnt_next;
    logic [7:0]   buzz_cnt, buzz_next;
    logic         done_q;
    logic         is_agitate, is_spin, is_illegal;
    logic         fwd_next, rev_next;
    logic [1:0]   speed_next, spin_speed;

    logic         fill_q, drain_q, fwd_q, rev_q, buzzer_q, fault_q;
    logic [1:0]   speed_q;

    assign is_agitate = (bus.stage == STAGE_WASH) || (bus.stage == STAGE_RINSE);
    assign is_spin    = (bus.stage == STAGE_SPIN);
    assign is_illegal = (bus.stage == 3'b101) || (bus.stage == 3'b110);

    // Motor sequencing; the registered speed doubles as the spin ramp step.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        spin_speed = speed_q;
        fwd_next   = 1'b0;
        rev_next   = 1'b0;
        speed_next = 2'b00;
        unique case (state)
            ST_OFF: begin
                if (is_agitate) begin
                    state_next = ST_FWD;
                    cnt_next   = '0;
                end else if (is_spin) begin
                    state_next = ST_SPIN;
                    cnt_next   = '0;
                end
            end
            ST_FWD, ST_REV: begin
                if (!is_agitate || cnt == AGITATE_LAST) begin
                    state_next = (state == ST_FWD) ? ST_DEAD_F : ST_DEAD_R;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_DEAD_F, ST_DEAD_R: begin
                if (cnt == DEAD_LAST) begin
                    cnt_next = '0;
                    if (is_agitate) begin
                        state_next = (state == ST_DEAD_F) ? ST_REV : ST_FWD;
                    end else if (is_spin) begin
                        state_next = ST_SPIN;
                    end else begin
                        state_next = ST_OFF;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_SPIN: begin
                if (!is_spin) begin
                    state_next = ST_DEAD_F;
                    cnt_next   = '0;
                end else if (speed_q != 2'b11) begin
                    if (cnt == RAMP_LAST) begin
                        spin_speed = speed_q + 2'd1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = '0;
            end
        endcase

        case (state_next)
            ST_FWD: begin
                fwd_next   = 1'b1;
                speed_next = 2'b01;
            end
            ST_REV: begin
                rev_next   = 1'b1;
                speed_next = 2'b01;
            end
            ST_SPIN: begin
                fwd_next   = 1'b1;
                speed_next = (state == ST_SPIN) ? spin_speed : 2'b01;
            end
            default: ;
        endcase
    end

    // Holding done high does not retrigger; only a fresh edge reloads the count.
    always_comb begin
        buzz_next = '0;
        if (bus.done && !done_q) begin
            buzz_next = BUZZ_LOAD;
        end else if (buzz_cnt != 8'd0) begin
            buzz_next = buzz_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_OFF;
            cnt      <= '0;
            buzz_cnt <= '0;
            done_q   <= 1'b0;
            fill_q   <= 1'b0;
            drain_q  <= 1'b0;
            fwd_q    <= 1'b0;
            rev_q    <= 1'b0;
            speed_q  <= 2'b00;
            buzzer_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            buzz_cnt <= buzz_next;
            done_q   <= bus.done;
            fill_q   <= (bus.stage == STAGE_FILL);
            drain_q  <= (bus.stage == STAGE_DRAIN) || is_spin;
            fwd_q    <= fwd_next;
            rev_q    <= rev_next;
            speed_q  <= speed_next;
            buzzer_q <= (buzz_next != 8'd0);
            fault_q  <= is_illegal;
        end
    end

    assign bus.fill_valve  = fill_q;
    assign bus.drain_valve = drain_q;
    assign bus.motor_fwd   = fwd_q;
    assign bus.motor_rev   = rev_q;
    assign bus.motor_speed = speed_q;
    assign bus.buzzer      = buzzer_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_awmc_actuator_drive.sv
// Self-checking bench for awmc_actuator_drive: directed scenarios followed by
// randomized stage/done traffic, all compared against a phase/countdown model.
module tb_awmc_actuator_drive;

    localparam int AGITATE_CYC = 8;
    localparam int DEAD_CYC    = 2;
    localparam int RAMP_CYC    = 4;
    localparam int BUZZ_CYC    = 6;

    localparam int PH_OFF  = 0;
    localparam int PH_AGIT = 1;
    localparam int PH_DEAD = 2;
    localparam int PH_SPIN = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int vector_count     = 0;
    int miscompare_count = 0;

    int         m_phase;
    int         m_dir;
    int         m_remain;
    int         m_age;
    int         m_buzz_left;
    bit         m_done_prev;
    logic [2:0] m_stage;

    int last_dir;
    int off_run;

    always #5 clk = ~clk;

    awmc_actuator_drive_if bus ();

    awmc_actuator_drive #(
        .AGITATE_CYC (AGITATE_CYC),
        .DEAD_CYC    (DEAD_CYC),
        .RAMP_CYC    (RAMP_CYC),
        .BUZZ_CYC    (BUZZ_CYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_phase     = PH_OFF;
        m_dir       = 1;
        m_remain    = 0;
        m_age       = 0;
        m_buzz_left = 0;
        m_done_prev = 1'b0;
        m_stage     = 3'b111;
        last_dir    = 0;
        off_run     = 0;
    endtask

    // Behavioural reference: one call per rising edge with the sampled inputs.
    task automatic model_step(input logic [2:0] st, input logic dn);
        bit agit;
        bit spin;
        agit    = (st == 3'd1) || (st == 3'd3);
        spin    = (st == 3'd4);
        m_stage = st;
        case (m_phase)
            PH_OFF: begin
                if (agit) begin
                    m_phase  = PH_AGIT;
                    m_dir    = 1;
                    m_remain = AGITATE_CYC - 1;
                end else if (spin) begin
                    m_phase = PH_SPIN;
                    m_age   = 0;
                end
            end
            PH_AGIT: begin
                if (!agit || m_remain == 0) begin
                    m_phase  = PH_DEAD;
                    m_remain = DEAD_CYC - 1;
                end else begin
                    m_remain--;
                end
            end
            PH_DEAD: begin
                if (m_remain == 0) begin
                    if (agit) begin
                        m_phase  = PH_AGIT;
                        m_dir    = -m_dir;
                        m_remain = AGITATE_CYC - 1;
                    end else if (spin) begin
                        m_phase = PH_SPIN;
                        m_age   = 0;
                    end else begin
                        m_phase = PH_OFF;
                    end
                end else begin
                    m_remain--;
                end
            end
            default: begin
                if (!spin) begin
                    m_phase  = PH_DEAD;
                    m_dir    = 1;
                    m_remain = DEAD_CYC - 1;
                end else begin
                    m_age++;
                end
            end
        endcase
        if (dn && !m_done_prev) m_buzz_left = BUZZ_CYC;
        else if (m_buzz_left > 0) m_buzz_left--;
        m_done_prev = dn;
    endtask

    function automatic logic [7:0] model_expect();
        logic fill, drain, fwd, rev, buzz, flt;
        logic [1:0] speed;
        int step;
        fill  = (m_stage == 3'd0);
        drain = (m_stage == 3'd2) || (m_stage == 3'd4);
        flt   = (m_stage == 3'd5) || (m_stage == 3'd6);
        fwd   = ((m_phase == PH_AGIT) && (m_dir > 0)) || (m_phase == PH_SPIN);
        rev   = (m_phase == PH_AGIT) && (m_dir < 0);
        step  = m_age / RAMP_CYC;
        if (m_phase == PH_AGIT)      speed = 2'b01;
        else if (m_phase == PH_SPIN) speed = (step >= 2) ? 2'b11 : 2'(1 + step);
        else                         speed = 2'b00;
        buzz  = (m_buzz_left > 0);
        return {fill, drain, fwd, rev, speed, buzz, flt};
    endfunction

    function automatic logic [7:0] observed_outputs();
        return {bus.fill_valve, bus.drain_valve, bus.motor_fwd, bus.motor_rev,
                bus.motor_speed, bus.buzzer, bus.fault};
    endfunction

    // Inputs change 1 time unit after an edge, outputs are sampled at the same point.
    task automatic applyStimulus(input logic [2:0] st, input logic dn);
        int cur;
        bus.stage = st;
        bus.done  = dn;
        @(posedge clk);
        model_step(st, dn);
        #1;
        checkOutput("outputs", 32'(observed_outputs()), 32'(model_expect()));
        checkOutput("fwd_rev_excl", 32'(bus.motor_fwd & bus.motor_rev), 32'd0);
        if (bus.motor_fwd || bus.motor_rev) begin
            cur = bus.motor_fwd ? 1 : -1;
            if (last_dir != 0 && cur != last_dir)
                checkOutput("dead_band", 32'(off_run >= DEAD_CYC), 32'd1);
            last_dir = cur;
            off_run  = 0;
        end else begin
            off_run++;
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checkOutput("reset_async", 32'(observed_outputs()), 32'(model_expect()));
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 32'(observed_outputs()), 32'd0);
        end
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int seg_len;
        int pick;
        logic [2:0] st;
        logic dn;

        bus.stage = 3'b111;
        bus.done  = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b0;
        #2;
        checkOutput("reset_state", 32'(observed_outputs()), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        $display("[TB] wash agitation");
        repeat (40) applyStimulus(3'd1, 1'b0);
        repeat (12) applyStimulus(3'd7, 1'b0);

        $display("[TB] spin ramp and async reset");
        repeat (14) applyStimulus(3'd4, 1'b0);
        checkOutput("spin_full", 32'(bus.motor_speed), 32'd3);
        do_reset();

        $display("[TB] pause and resume");
        repeat (5)  applyStimulus(3'd1, 1'b0);
        repeat (3)  applyStimulus(3'd7, 1'b0);
        repeat (12) applyStimulus(3'd1, 1'b0);
        repeat (10) applyStimulus(3'd7, 1'b0);

        $display("[TB] buzzer");
        repeat (20) applyStimulus(3'd7, 1'b1);
        repeat (5)  applyStimulus(3'd7, 1'b0);

        $display("[TB] illegal stage");
        repeat (2) applyStimulus(3'd6, 1'b0);
        repeat (2) applyStimulus(3'd0, 1'b0);

        $display("[TB] done held through reset");
        bus.done = 1'b1;
        do_reset();
        repeat (8) applyStimulus(3'd7, 1'b1);

        $display("[TB] randomized traffic");
        dn = 1'b0;
        for (int seg = 0; seg < 300; seg++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2, 3, 4: st = 3'(pick);
                5, 6:          st = 3'd7;
                7:             st = 3'd1;
                8:             st = 3'd4;
                default:       st = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
            endcase
            seg_len = $urandom_range(1, 24);
            for (int c = 0; c < seg_len; c++) begin
                if ($urandom_range(0, 7) == 0) dn = ~dn;
                applyStimulus(st, dn);
            end
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
